// File: rtl/int2float_arbiter.sv
// int2float_arbiter: two-requester round-robin front end sharing one int32 -> IEEE-754 single converter.
// Latency: operand captured on the accept edge, result valid after the following edge (3-cycle issue interval).
// Backpressure: result is held stable until res_ready; no operand is accepted until the result is consumed.
//
// Ports:
//   clk, rst                    clock and async active-high reset
//   req0_valid/data/ready       requester 0 operand handshake
//   req1_valid/data/ready       requester 1 operand handshake
//   res_valid/data/id/ready     tagged result handshake
//   busy                        FSM not idle
//   conv_count                  results consumed since reset (wraps)

// Converter: combinational signed 32-bit integer to IEEE-754 single precision,
// round-to-nearest-even. Zero maps to +0.
module Converter (
  input  logic [31:0] number,
  output logic [31:0] float
);
  logic        sign;
  logic [31:0] mag;
  logic [30:0] norm;
  logic [4:0]  msb;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_rnd;
  logic [7:0]  exp_b;

  always_comb begin
    sign = number[31];
    // -2^31 negates to 0x80000000, which is the correct unsigned magnitude.
    mag  = sign ? (~number + 32'd1) : number;
    msb  = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    // Left-justify so the leading one would sit at bit 31 (dropped, it is implicit).
    norm     = mag[30:0] << (5'd31 - msb);
    mant     = norm[30:8];
    guard    = norm[7];
    sticky   = |norm[6:0];
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {23'd0, round_up};
    // A mantissa carry-out bumps the exponent; the stored fraction is then zero.
    exp_b    = 8'd127 + {3'd0, msb} + {7'd0, mant_rnd[23]};
    if (mag == 32'd0) float = 32'd0;
    else              float = {sign, exp_b, mant_rnd[22:0]};
  end
endmodule

module int2float_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] conv_count
);
  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] operand;
  logic [31:0] conv_float;
  logic        op_id;
  logic        last_grant;
  logic        grant_vld;
  logic        grant_id;

  Converter u_conv (
    .number (operand),
    .float  (conv_float)
  );

  always_comb begin
    state_nxt  = state;
    grant_vld  = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        grant_vld = req0_valid | req1_valid;
        // On a tie the requester not granted last time wins; otherwise the lone requester.
        grant_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        req0_ready = grant_vld & ~grant_id;
        req1_ready = grant_vld &  grant_id;
        if (grant_vld) state_nxt = CONVERT;
      end
      CONVERT: state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      operand    <= 32'd0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;   // requester 0 wins the first tie
      res_valid  <= 1'b0;
      res_data   <= 32'd0;
      res_id     <= 1'b0;
      conv_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            operand    <= grant_id ? req1_data : req0_data;
            op_id      <= grant_id;
            last_grant <= grant_id;
          end
        end
        CONVERT: begin
          res_data  <= conv_float;
          res_id    <= op_id;
          res_valid <= 1'b1;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            conv_count <= conv_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_int2float_arbiter.sv
module tb_int2float_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, res_ready;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, res_valid, res_id, busy;
  logic [31:0] res_data;
  logic [15:0] conv_count;
  // Narrow-counter instance shares all inputs; only its count is observed.
  logic        w_req0_ready, w_req1_ready, w_res_valid, w_res_id, w_busy;
  logic [31:0] w_res_data;
  logic [1:0]  w_conv_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  int2float_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .busy(busy), .conv_count(conv_count)
  );

  int2float_arbiter #(.CNT_W(2)) dut_w (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(w_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(w_req1_ready),
    .res_valid(w_res_valid), .res_data(w_res_data), .res_id(w_res_id), .res_ready(res_ready),
    .busy(w_busy), .conv_count(w_conv_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt"},  32'(conv_count),   32'(exp_cnt));
    chk({tag, "_wcnt"}, 32'(w_conv_count), 32'(exp_cnt % 4));
  endtask

  // Entry: just after an edge with the FSM in IDLE. Runs one full transaction.
  task automatic one_conv(input logic who, input logic [31:0] d, input logic [31:0] exp_f);
    if (who) begin req1_valid = 1'b1; req1_data = d; end
    else     begin req0_valid = 1'b1; req0_data = d; end
    res_ready = 1'b1;
    #1;
    chk("acc_rdy", {30'd0, req1_ready, req0_ready}, who ? 32'd2 : 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("cvt_busy", 32'(busy), 32'd1);
    chk("cvt_vld",  32'(res_valid), 32'd0);
    tick();
    chk("hold_vld",  32'(res_valid), 32'd1);
    chk("hold_data", res_data, exp_f);
    chk("hold_id",   32'(res_id), 32'(who));
    tick();
    exp_cnt++;
    chk("done_vld", 32'(res_valid), 32'd0);
    chk_counts("done");
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_data = 32'd0; req1_data = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_vld",  32'(res_valid), 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_id",   32'(res_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_counts("rst");
    rst = 1'b0;
    tick();

    // Directed conversions with hand-computed IEEE-754 encodings.
    one_conv(1'b0, 32'h1000_0000, 32'h4D80_0000);  // 2^28
    one_conv(1'b1, 32'hF000_0000, 32'hCD80_0000);  // -2^28
    one_conv(1'b0, 32'h0000_0000, 32'h0000_0000);  // 0
    one_conv(1'b0, 32'd1078,      32'h4486_C000);  // 2^10+54
    one_conv(1'b1, 32'h7FFF_FFFF, 32'h4F00_0000);  // rounds up to 2^31
    one_conv(1'b0, 32'h8000_0000, 32'hCF00_0000);  // -2^31
    one_conv(1'b1, 32'h0100_0001, 32'h4B80_0000);  // tie, even stays
    one_conv(1'b0, 32'h0100_0003, 32'h4B80_0002);  // tie, odd rounds up

    // Backpressure: result held for 10 cycles while both requesters wait.
    req0_valid = 1'b1; req0_data = 32'd5; res_ready = 1'b0;
    #1;
    chk("bp_acc", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b1; req0_data = 32'd9;
    req1_valid = 1'b1; req1_data = 32'd11;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld",  32'(res_valid), 32'd1);
      chk("bp_data", res_data, 32'h40A0_0000);
      chk("bp_id",   32'(res_id), 32'd0);
      chk("bp_rdy",  {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("bp_rel_vld",  32'(res_valid), 32'd0);
    chk("bp_rel_busy", 32'(busy), 32'd0);
    chk_counts("bp_rel");
    // Last grant was 0, so the tie now goes to requester 1.
    chk("bp_tie", {30'd0, req1_ready, req0_ready}, 32'd2);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Reset while in CONVERT drops the transaction.
    req0_valid = 1'b1; req0_data = 32'd7;
    #1;
    chk("mr_acc", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    chk("mr_vld",  32'(res_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk_counts("mr");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_quiet_vld",  32'(res_valid), 32'd0);
      chk("mr_quiet_busy", 32'(busy), 32'd0);
    end

    // Round-robin with both requesters continuously valid; first tie goes to 0.
    req0_valid = 1'b1; req0_data = 32'd3;          // 3.0
    req1_valid = 1'b1; req1_data = 32'hFFFF_FFFF;  // -1.0
    res_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", {30'd0, req1_ready, req0_ready}, (i % 2 == 1) ? 32'd2 : 32'd1);
      tick();
      chk("rr_cvt_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("rr_cvt_busy", 32'(busy), 32'd1);
      tick();
      chk("rr_vld",  32'(res_valid), 32'd1);
      chk("rr_id",   32'(res_id), 32'(i % 2));
      chk("rr_data", res_data, (i % 2 == 1) ? 32'hBF80_0000 : 32'h4040_0000);
      chk("rr_hold_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
      exp_cnt++;
      chk("rr_done_vld", 32'(res_valid), 32'd0);
      chk_counts("rr");
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end

    // Fifth conversion since reset: narrow counter wraps to 1.
    one_conv(1'b0, 32'd100, 32'h42C8_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
